// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_conditioner
// Purpose  : Per-bit conditioning of raw GPIO pad readback. Each bit is
//            synchronised into Clk, debounced, edge-detected, and feeds a
//            sticky interrupt status register with per-bit mask and
//            write-1-to-clear.
// Ports    : Clk, Reset_n  - clock, asynchronous active-low reset
//            Pins          - raw pad readback (asynchronous to Clk)
//            RiseEn/FallEn - per-bit edge enables for IrqStatus
//            IrqMask       - per-bit mask for Irq (1 = enabled)
//            IrqClear      - per-bit write-1-to-clear strobe
//            Level         - debounced, synchronised level
//            RisePulse     - one-cycle pulse on debounced 0->1
//            FallPulse     - one-cycle pulse on debounced 1->0
//            IrqStatus     - sticky interrupt status
//            Irq           - OR of (IrqStatus & IrqMask)
// Revision : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner #(
    parameter int   WIDTH           = 8,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Pins,
    input  logic [WIDTH-1:0] RiseEn,
    input  logic [WIDTH-1:0] FallEn,
    input  logic [WIDTH-1:0] IrqMask,
    input  logic [WIDTH-1:0] IrqClear,
    output logic [WIDTH-1:0] Level,
    output logic [WIDTH-1:0] RisePulse,
    output logic [WIDTH-1:0] FallPulse,
    output logic [WIDTH-1:0] IrqStatus,
    output logic             Irq
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   synced;
        logic [CNT_W-1:0]       cnt;
        logic                   flip;

        assign synced = sync_q[SYNC_STAGES-1];
        // Level flips once the differing value has been seen on DEBOUNCE_CYCLES
        // consecutive edges; any return to Level restarts the count.
        assign flip   = (synced != Level[i]) && (cnt == CNT_MAX);

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                sync_q       <= {SYNC_STAGES{RESET_LEVEL}};
                cnt          <= '0;
                Level[i]     <= RESET_LEVEL;
                RisePulse[i] <= 1'b0;
                FallPulse[i] <= 1'b0;
                IrqStatus[i] <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], Pins[i]};

                if (synced == Level[i] || flip) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                if (flip) begin
                    Level[i] <= synced;
                end

                RisePulse[i] <= flip & synced;
                FallPulse[i] <= flip & ~synced;

                // A new event takes priority over a simultaneous clear so
                // software never loses an edge it has not yet seen.
                if ((flip & synced & RiseEn[i]) | (flip & ~synced & FallEn[i])) begin
                    IrqStatus[i] <= 1'b1;
                end else if (IrqClear[i]) begin
                    IrqStatus[i] <= 1'b0;
                end
            end
        end
    end

    assign Irq = |(IrqStatus & IrqMask);

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_conditioner
// Purpose  : Self-checking bench for gpio_input_conditioner. A default
//            instance is checked every cycle against a window-based reference
//            model; a second instance (WIDTH=4, SYNC_STAGES=3,
//            DEBOUNCE_CYCLES=1) is checked for its latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_conditioner;

    localparam int   W  = 8;
    localparam int   S  = 2;
    localparam int   D  = 4;
    localparam logic RL = 1'b0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pins, rise_en, fall_en, irq_mask, irq_clear;
    logic [W-1:0] level, rise_p, fall_p, status;
    logic         irq;

    logic [3:0]   pins1;
    logic [3:0]   level1, rise1, fall1, status1;
    logic         irq1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .Pins(pins), .RiseEn(rise_en),
        .FallEn(fall_en), .IrqMask(irq_mask), .IrqClear(irq_clear),
        .Level(level), .RisePulse(rise_p), .FallPulse(fall_p),
        .IrqStatus(status), .Irq(irq)
    );

    gpio_input_conditioner #(
        .WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)
    ) dut1 (
        .Clk(clk), .Reset_n(rst_n), .Pins(pins1), .RiseEn(4'h0),
        .FallEn(4'h0), .IrqMask(4'h0), .IrqClear(4'h0),
        .Level(level1), .RisePulse(rise1), .FallPulse(fall1),
        .IrqStatus(status1), .Irq(irq1)
    );

    // Reference model: history of captured pin vectors and of the values the
    // conditioner sees after synchronisation; a bit flips when the last D
    // seen values all differ from the current level.
    logic [W-1:0] cap_q[$];
    logic [W-1:0] seen_q[$];
    logic [W-1:0] m_lvl, m_rise, m_fall, m_stat;

    task automatic model_reset();
        cap_q  = {};
        seen_q = {};
        for (int k = 0; k < S; k++) cap_q.push_back({W{RL}});
        m_lvl  = {W{RL}};
        m_rise = '0;
        m_fall = '0;
        m_stat = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] seen, flip;
        seen = cap_q[0];
        cap_q.push_back(pins);
        void'(cap_q.pop_front());
        seen_q.push_back(seen);
        if (seen_q.size() > D) void'(seen_q.pop_front());
        flip = '0;
        for (int i = 0; i < W; i++) begin
            if (seen_q.size() == D) begin
                flip[i] = 1'b1;
                foreach (seen_q[j]) if (seen_q[j][i] == m_lvl[i]) flip[i] = 1'b0;
            end
        end
        m_rise = flip & seen;
        m_fall = flip & ~seen;
        m_lvl  = m_lvl ^ flip;
        m_stat = (m_rise & rise_en) | (m_fall & fall_en) | (m_stat & ~irq_clear);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("level", level, m_lvl);
        chk("rise", rise_p, m_rise);
        chk("fall", fall_p, m_fall);
        chk("status", status, m_stat);
        chk("irq", {7'b0, irq}, {7'b0, |(m_stat & irq_mask)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    initial begin
        rst_n = 1'b0; pins = '0; rise_en = '0; fall_en = '0;
        irq_mask = '0; irq_clear = '0; pins1 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all();
        chk("level1_reset", {4'b0, level1}, 8'h00);
        rst_n = 1'b1;

        // Single rising bit: Level[0] flips on the sixth edge (edge 5).
        pins = 8'h01;
        for (int j = 0; j <= 7; j++) begin
            step();
            if (j == 4) chk("lvl0_pre", {7'b0, level[0]}, 8'h00);
            if (j == 5) chk("lvl0_edge5", {7'b0, level[0]}, 8'h01);
            if (j == 5) chk("rise0_edge5", rise_p, 8'h01);
        end

        // Glitch of 3 cycles is filtered, 4 cycles passes.
        pins = 8'h09; repeat (3) step();
        pins = 8'h01; repeat (8) step();
        chk("glitch3_level", level, 8'h01);
        pins = 8'h09; repeat (4) step();
        pins = 8'h01; repeat (8) step();

        // Rise interrupts, clear, and combinational unmask.
        rise_en = 8'hFF; irq_mask = 8'h0F;
        pins = 8'h45; repeat (7) step();
        chk("stat_44", status, 8'h44);
        chk("irq_44", {7'b0, irq}, 8'h01);
        irq_clear = 8'h04; step();
        irq_clear = 8'h00; step();
        chk("stat_40", status, 8'h40);
        chk("irq_masked", {7'b0, irq}, 8'h00);
        irq_mask = 8'hFF; #1;
        chk("irq_unmask", {7'b0, irq}, 8'h01);

        // Falling event and clear on the same edge: set wins.
        fall_en = 8'h20;
        pins = 8'h65; repeat (7) step();
        irq_clear = 8'h20; step();
        irq_clear = 8'h00; step();
        pins = 8'h45;
        for (int j = 0; j <= 5; j++) begin
            if (j == 5) irq_clear = 8'h20;
            step();
        end
        irq_clear = 8'h00;
        chk("fall5_pulse", fall_p, 8'h20);
        chk("set_wins", {7'b0, status[5]}, 8'h01);
        step();

        // Reset mid-count, then full latency after release.
        pins = 8'hFF; repeat (2) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            step();
            if (j == 4) chk("rst_lvl_pre", level, 8'h00);
            if (j == 5) chk("rst_lvl_ff", level, 8'hFF);
            if (j == 5) chk("rst_rise_ff", rise_p, 8'hFF);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) pins = pins ^ W'($urandom);
            rise_en   = W'($urandom);
            fall_en   = W'($urandom);
            irq_mask  = W'($urandom);
            irq_clear = ($urandom_range(3) == 0) ? W'($urandom) : '0;
            step();
        end
        irq_clear = '0;

        // Second instance: capture at edge k updates Level at edge k+3.
        pins1 = 4'hA;
        for (int j = 0; j <= 3; j++) begin
            step();
            if (j == 2) chk("lat1_pre", {4'b0, level1}, 8'h00);
            if (j == 3) chk("lat1_hit", {4'b0, level1}, 8'h0A);
        end
        pins1 = 4'h5;
        for (int j = 0; j <= 3; j++) begin
            step();
            if (j == 2) chk("lat2_pre", {4'b0, level1}, 8'h0A);
            if (j == 3) chk("lat2_hit", {4'b0, level1}, 8'h05);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
